uart_tx_buffered: RTL
=====================

# uart_tx_buffered

Memory-mapped UART transmitter sitting directly downstream of the single-cycle MIPS core's RAM/peripheral address decoder. CPU stores to the TX data address push bytes into a small FIFO; a store to the TX start address drains the FIFO as back-to-back 8N1 frames on `SerialDataOut`. A sticky completion flag, cleared by the decoder's `clr_tx_flag`, is read back by software polling.

## Interface
- `UART_Nbit`, 8, data bits per frame.
- `baudrate`, 9600, line rate in bit/s.
- `clk_freq`, 50000000, clock frequency in Hz; `CLKS_PER_BIT = clk_freq/baudrate` (integer division, must be ≥2).
- `FIFO_DEPTH`, 4, byte entries (power of two).

Ports:
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low.
- `wdata` input UART_Nbit: byte to enqueue (RD2[UART_Nbit-1:0] from the core).
- `store_en` input 1: one-cycle push strobe (decoder `enable_StoreTxbuff`).
- `start` input 1: one-cycle arm strobe (decoder `Start_uart_tx`).
- `clr_tx_flag` input 1: clears `tx_flag` and `overflow`.
- `SerialDataOut` output 1: serial line, idle high.
- `tx_busy` output 1: high while a frame is on the line.
- `tx_flag` output 1: sticky "burst complete".
- `fifo_count` output clog2(FIFO_DEPTH)+1: entries queued.
- `fifo_full` output 1: `fifo_count == FIFO_DEPTH`.
- `overflow` output 1: sticky, a push was dropped.

## Operation
- Reset values: `SerialDataOut`=1, `tx_busy`=0, `tx_flag`=0, `fifo_count`=0, `fifo_full`=0, `overflow`=0; FSM in IDLE, baud counter 0, FIFO pointers 0.
- FIFO: circular, write/read pointers wrap at FIFO_DEPTH. Push when `store_en` and (not full, or a pop occurs the same cycle). Push while full without pop: byte dropped, `overflow`←1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if `start`=1 and FIFO non-empty: pop head into shift register, bit index←0, →START. `start` with empty FIFO is ignored. `start` outside IDLE is ignored.
  - START: line 0 for CLKS_PER_BIT cycles, →DATA.
  - DATA: line = shift[0], LSB first; each CLKS_PER_BIT cycles shift right, index+1; after UART_Nbit bits →STOP.
  - STOP: line 1 for CLKS_PER_BIT cycles. At end: FIFO non-empty → pop next byte, →START (no idle gap); empty → IDLE, `tx_flag`←1.
- Bytes pushed during a burst are sent in the same burst if they arrive before the final STOP ends.
- `tx_flag` set and `clr_tx_flag` in same cycle: set wins. `overflow` set and clear same cycle: set wins.
- Pop and push in the same cycle: count unchanged, both pointers advance.

## Timing
- `SerialDataOut` and `tx_busy` are registered outputs.
- `start` sampled at edge t (FIFO non-empty): `SerialDataOut`=0 and `tx_busy`=1 from t+1.
- Frame = (UART_Nbit+2)·CLKS_PER_BIT cycles; consecutive frames abut exactly.
- `fifo_count` reflects a push/pop one cycle after the strobe/pop edge.
- `tx_flag` and `tx_busy`=0 visible the cycle after the last stop-bit cycle.
- Reset asserted mid-frame: line returns high immediately (async), FIFO contents discarded; frame is truncated, not completed.

## Test plan
- clk_freq=50, baudrate=5 (10 clk/bit): push 0xA5, pulse start → line 0 for 10 cycles, bits 1,0,1,0,0,1,0,1 each 10 cycles, 1 for 10 cycles; `tx_flag`=1 at cycle 101 after start; `clr_tx_flag` → 0.
- Push 0x01,0x02,0x03, start → three frames back-to-back, 300 cycles total, no idle-high gap between stop and next start; `fifo_count` 3→2→1→0 at each frame start.
- Push 5 bytes with FIFO_DEPTH=4 while idle → `fifo_full`=1, `overflow`=1, `fifo_count`=4; first four bytes transmitted, fifth absent.
- Start with empty FIFO → line stays 1, `tx_busy`=0, `tx_flag` stays 0; push 0x55 mid-burst of 0x00 → 0x55 follows without re-start.
- Assert reset during DATA bit 3 → `SerialDataOut`=1, `fifo_count`=0, `tx_busy`=0 immediately; post-reset push 0xFF + start transmits cleanly.
- `clr_tx_flag` coincident with final STOP end → `tx_flag`=1 (set wins).

Source files
------------

// File: rtl/uart_tx_buffered.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO.
// A start strobe drains the FIFO as back-to-back frames and raises a sticky completion flag.
module uart_tx_buffered #(
  parameter int unsigned UART_Nbit  = 8,
  parameter int unsigned baudrate   = 9600,
  parameter int unsigned clk_freq   = 50000000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [UART_Nbit-1:0]          wdata,
  input  logic                          store_en,
  input  logic                          start,
  input  logic                          clr_tx_flag,
  output logic                          SerialDataOut,
  output logic                          tx_busy,
  output logic                          tx_flag,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          overflow
);

  localparam int unsigned CLKS_PER_BIT = clk_freq / baudrate;
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = (UART_Nbit > 1) ? $clog2(UART_Nbit) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] CntLast   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IdxLast   = IDX_W'(UART_Nbit - 1);
  localparam logic [PTR_W-1:0] PtrLast   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0]    CountFull = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [UART_Nbit-1:0] shift_q, shift_d;
  logic                 line_q, line_d;
  logic                 busy_q, busy_d;
  logic                 flag_q, flag_d;
  logic                 ovf_q, ovf_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [UART_Nbit-1:0] mem_q [FIFO_DEPTH];

  logic empty, full, bit_end, pop, push, drop, flag_set;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CountFull);
  assign bit_end = (cnt_q == CntLast);

  // Transmit FSM; a pop loads the head byte straight into the shift register.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    flag_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && !empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          idx_d   = '0;
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == IdxLast) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            idx_d   = '0;
            state_d = StStart;
          end else begin
            flag_set = 1'b1;
            state_d  = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line and busy are registered from the next state so they track it with no extra lag.
  always_comb begin
    line_d = 1'b1;
    case (state_d)
      StStart: line_d = 1'b0;
      StData:  line_d = shift_d[0];
      default: line_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
  end

  // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
  always_comb begin
    push     = store_en && (!full || pop);
    drop     = store_en && full && !pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    flag_d = flag_set | (flag_q & ~clr_tx_flag);
    ovf_d  = drop | (ovf_q & ~clr_tx_flag);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      line_q   <= 1'b1;
      busy_q   <= 1'b0;
      flag_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      line_q   <= line_d;
      busy_q   <= busy_d;
      flag_q   <= flag_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign SerialDataOut = line_q;
  assign tx_busy       = busy_q;
  assign tx_flag       = flag_q;
  assign fifo_count    = count_q;
  assign fifo_full     = full;
  assign overflow      = ovf_q;

endmodule
